ws2812b_frame_tx: RTL and testbench

//   Serializes a parallel LED colour frame onto the single WS2812B data line with correct
//   per-bit pulse timing, then holds the line low for the latch/reset interval.
//   It sits downstream of the pattern generators that produce the 96-bit GRB frame
//   (4 LEDs x 24 bits), and is the only block that drives the BASYS 3 LED-strip pin.

---
 rtl/ws2812b_frame_tx.sv | 111 +++++++++++
 tb/tb_ws2812b_frame_tx.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ws2812b_frame_tx.sv
// rtl/ws2812b_frame_tx.sv - WS2812B frame serializer with per-bit pulse timing and latch hold
module ws2812b_frame_tx #(
    parameter int NUM_LEDS     = 4,
    parameter int BIT_CYCLES   = 125,
    parameter int T0H_CYCLES   = 40,
    parameter int T1H_CYCLES   = 80,
    parameter int LATCH_CYCLES = 5000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_LEDS*24-1:0]  frame,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    dout
);

    localparam int FRAME_BITS = NUM_LEDS * 24;
    localparam int CNT_MAX    = (LATCH_CYCLES > BIT_CYCLES) ? LATCH_CYCLES : BIT_CYCLES;
    localparam int CNT_W      = $clog2(CNT_MAX);
    localparam int BIT_W      = $clog2(FRAME_BITS + 1);

    // Terminal counts: the cycle counter runs 0..N-1 within each phase
    localparam logic [CNT_W-1:0] T0H_LAST   = CNT_W'(T0H_CYCLES - 1);
    localparam logic [CNT_W-1:0] T1H_LAST   = CNT_W'(T1H_CYCLES - 1);
    localparam logic [CNT_W-1:0] L0_LAST    = CNT_W'(BIT_CYCLES - T0H_CYCLES - 1);
    localparam logic [CNT_W-1:0] L1_LAST    = CNT_W'(BIT_CYCLES - T1H_CYCLES - 1);
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        LATCH = 2'd3
    } state_t;

    state_t                  state;
    logic [FRAME_BITS-1:0]   shiftReg;
    logic [BIT_W-1:0]        bitCnt;
    logic [CNT_W-1:0]        cycleCnt;
    logic [CNT_W-1:0]        highLast;
    logic [CNT_W-1:0]        lowLast;

    always_comb begin
        highLast = shiftReg[FRAME_BITS-1] ? T1H_LAST : T0H_LAST;
        lowLast  = shiftReg[FRAME_BITS-1] ? L1_LAST  : L0_LAST;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            shiftReg <= '0;
            bitCnt   <= '0;
            cycleCnt <= '0;
            dout     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shiftReg <= frame;
                        bitCnt   <= BIT_W'(FRAME_BITS);
                        cycleCnt <= '0;
                        dout     <= 1'b1;
                        busy     <= 1'b1;
                        state    <= HIGH;
                    end
                end
                HIGH: begin
                    if (cycleCnt == highLast) begin
                        cycleCnt <= '0;
                        dout     <= 1'b0;
                        state    <= LOW;
                    end else begin
                        cycleCnt <= cycleCnt + CNT_W'(1);
                    end
                end
                LOW: begin
                    if (cycleCnt == lowLast) begin
                        // Bit period complete: advance to the next bit with no gap
                        cycleCnt <= '0;
                        shiftReg <= {shiftReg[FRAME_BITS-2:0], 1'b0};
                        bitCnt   <= bitCnt - BIT_W'(1);
                        if (bitCnt == BIT_W'(1)) begin
                            state <= LATCH;
                        end else begin
                            dout  <= 1'b1;
                            state <= HIGH;
                        end
                    end else begin
                        cycleCnt <= cycleCnt + CNT_W'(1);
                    end
                end
                LATCH: begin
                    if (cycleCnt == LATCH_LAST) begin
                        cycleCnt <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cycleCnt <= cycleCnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812b_frame_tx.sv
// tb/tb_ws2812b_frame_tx.sv - directed bench decoding WS2812B pulse widths from ws2812b_frame_tx
module tb_ws2812b_frame_tx;

    localparam int FW        = 96;
    localparam int BITC      = 125;
    localparam int T0H       = 40;
    localparam int T1H       = 80;
    localparam int LATCHC    = 5000;
    localparam int FRAME_LEN = FW * BITC + LATCHC;

    localparam logic [FW-1:0] FRAME_A  = 96'h00F000_0000F0_00F000_0000F0;
    localparam logic [FW-1:0] FRAME_B  = 96'hA5A5A5_5A5A5A_C3C3C3_3C3C3C;
    localparam logic [FW-1:0] MSB_ONLY = 96'h800000_000000_000000_000000;

    logic          clk = 1'b0;
    logic          reset;
    logic [FW-1:0] frame;
    logic          start;
    logic          busy;
    logic          done;
    logic          dout;

    int total = 0;
    int bad   = 0;

    ws2812b_frame_tx dut (
        .clk   (clk),
        .reset (reset),
        .frame (frame),
        .start (start),
        .busy  (busy),
        .done  (done),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered on the first negedge after the accepting edge (sample index 0);
    // returns on the sample where done is first seen.
    task automatic runFrame(input string tag, input logic [FW-1:0] expBits,
                            input bit changeAt20, input logic [FW-1:0] newFrame,
                            input bit pulseAt10);
        int pulses   = 0;
        int riseAt   = 0;
        int lastFall = 0;
        int doneAt   = -1;
        int widthErr = 0;
        int spaceErr = 0;
        int busyErr  = 0;
        int firstHi  = 0;
        int secondHi = 0;
        int hw;
        logic prev = 1'b0;
        logic [FW-1:0] got = '0;
        for (int c = 0; c < FRAME_LEN + 100; c++) begin
            if (dout && !prev) begin
                if (c != pulses * BITC) spaceErr++;
                riseAt = c;
                pulses++;
            end else if (!dout && prev) begin
                hw = c - riseAt;
                if (hw != T0H && hw != T1H) widthErr++;
                if (pulses == 1) firstHi = hw;
                if (pulses == 2) secondHi = hw;
                if (pulses <= FW) got[FW-pulses] = (hw == T1H);
                lastFall = c;
            end
            if (done) begin
                doneAt = c;
                if (busy) busyErr++;
                break;
            end
            if (!busy) busyErr++;
            prev = dout;
            if (changeAt20 && c == 20 * BITC + 3) frame = newFrame;
            if (pulseAt10 && c == 10 * BITC + 3) start = 1'b1;
            if (pulseAt10 && c == 10 * BITC + 4) start = 1'b0;
            @(negedge clk);
        end
        chk({tag, "_pulses"}, FW'(pulses), FW'(FW));
        chk({tag, "_bits"}, got, expBits);
        chk({tag, "_done_cycle"}, FW'(doneAt), FW'(FRAME_LEN));
        chk({tag, "_width_errs"}, FW'(widthErr), '0);
        chk({tag, "_spacing_errs"}, FW'(spaceErr), '0);
        chk({tag, "_busy_errs"}, FW'(busyErr), '0);
        chk({tag, "_first_high"}, FW'(firstHi), FW'(expBits[FW-1] ? T1H : T0H));
        chk({tag, "_second_high"}, FW'(secondHi), FW'(expBits[FW-2] ? T1H : T0H));
        chk({tag, "_latch_low"}, FW'(doneAt - lastFall),
            FW'(BITC - (expBits[0] ? T1H : T0H) + LATCHC));
    endtask

    initial begin
        int errs;
        int rises;
        int doneSeen;
        logic prev;

        // Reset held with start asserted: outputs must stay quiet
        reset = 1'b0;
        start = 1'b1;
        frame = FRAME_A;
        errs  = 0;
        repeat (20) begin
            @(negedge clk);
            if (dout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) errs++;
        end
        chk("reset_outputs", FW'(errs), '0);

        start = 1'b0;
        reset = 1'b1;
        errs  = 0;
        repeat (20) begin
            @(negedge clk);
            if (dout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) errs++;
        end
        chk("idle_no_start", FW'(errs), '0);

        // Frame A with start held high throughout; frame input changed mid-frame
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        runFrame("frameA", FRAME_A, 1'b1, FRAME_B, 1'b0);
        chk("gap_done", FW'(done), FW'(1));
        chk("gap_busy", FW'(busy), FW'(0));
        chk("gap_dout", FW'(dout), FW'(0));

        // Back-to-back: next frame starts one cycle after done
        @(negedge clk);
        chk("b2b_dout", FW'(dout), FW'(1));
        chk("b2b_busy", FW'(busy), FW'(1));
        chk("b2b_done", FW'(done), FW'(0));
        start = 1'b0;

        // Walk frame B to bit 50 (inside its high phase), then reset
        rises    = 1;
        doneSeen = 0;
        prev     = 1'b1;
        for (int c = 1; c <= 50 * BITC + 10; c++) begin
            @(negedge clk);
            if (dout && !prev) rises++;
            prev = dout;
            if (done) doneSeen++;
        end
        chk("pre_abort_pulses", FW'(rises), FW'(51));
        chk("pre_abort_dout", FW'(dout), FW'(1));
        reset = 1'b0;
        #1;
        chk("abort_dout", FW'(dout), FW'(0));
        chk("abort_busy", FW'(busy), FW'(0));
        chk("abort_done", FW'(done), FW'(0));
        repeat (5) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        reset = 1'b1;
        errs  = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) doneSeen++;
            if (dout !== 1'b0 || busy !== 1'b0) errs++;
        end
        chk("abort_no_done", FW'(doneSeen), '0);
        chk("abort_idle", FW'(errs), '0);

        // Full frame after abort, with a start pulse that must be ignored at bit 10
        frame = MSB_ONLY;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        runFrame("msb", MSB_ONLY, 1'b0, '0, 1'b1);
        doneSeen = 0;
        errs     = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) doneSeen++;
            if (dout !== 1'b0 || busy !== 1'b0) errs++;
        end
        chk("single_done", FW'(doneSeen), '0);
        chk("post_idle", FW'(errs), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
